// File: rtl/tcp_misc_pkg.sv
// ---------------------------------------------------------------------------
// tcp_misc_pkg
// Shared types for the TX dispatch path: packet type, per-flag command
// encoding and the scheduler request/command structures.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tcp_misc_pkg;

  localparam int FLOWID_W = 10;

  // Packet type; the value doubles as the bit index in the pending vector.
  typedef enum logic [1:0] {
    PKT_RT   = 2'd0,
    PKT_DATA = 2'd1,
    PKT_ACK  = 2'd2
  } tx_pkt_type_e;

  // Per-flag command sent back to the scheduler.
  typedef enum logic [1:0] {
    FLAG_NOP   = 2'd0,
    FLAG_SET   = 2'd1,
    FLAG_CLEAR = 2'd2
  } flag_cmd_e;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    logic                rt_flag;
    logic                ack_pend_flag;
    logic                data_pend_flag;
  } sched_data_struct;

  typedef struct packed {
    logic [FLOWID_W-1:0] flowid;
    flag_cmd_e           rt_set_clear;
    flag_cmd_e           ack_pend_set_clear;
    flag_cmd_e           data_pend_set_clear;
  } sched_cmd_struct;

  localparam int SCHED_DATA_STRUCT_W = $bits(sched_data_struct);
  localparam int SCHED_CMD_STRUCT_W  = $bits(sched_cmd_struct);

  // A flag is only cleared when this dispatch actually serviced it.
  function automatic flag_cmd_e clr_if_serviced(input logic serviced);
    return serviced ? FLAG_CLEAR : FLAG_NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_pkt_prio_sel.sv
// ---------------------------------------------------------------------------
// tx_pkt_prio_sel
// Combinational priority pick over the pending vector: RT > DATA > ACK.
// Returns the packet type and the one-hot bit that was selected.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_pkt_prio_sel
  import tcp_misc_pkg::*;
(
  input  logic [2:0]   pend_i,
  output tx_pkt_type_e type_o,
  output logic [2:0]   onehot_o
);

  // Lowest set index wins; an empty vector selects nothing.
  always_comb begin
    type_o   = PKT_RT;
    onehot_o = 3'b000;
    if (pend_i[0]) begin
      type_o   = PKT_RT;
      onehot_o = 3'b001;
    end else if (pend_i[1]) begin
      type_o   = PKT_DATA;
      onehot_o = 3'b010;
    end else if (pend_i[2]) begin
      type_o   = PKT_ACK;
      onehot_o = 3'b100;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_sched_dispatch.sv
// ---------------------------------------------------------------------------
// tx_sched_dispatch
// Takes one flow at a time from the scheduler, issues one packet request per
// pending flag in priority order, then returns a flag-clear command covering
// exactly the flags that were serviced.
// Optional build macro: TX_DISPATCH_ACK_PIGGYBACK_EN (ACK rides on DATA).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_sched_dispatch
  import tcp_misc_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_tx_req_val,
  input  logic [SCHED_DATA_STRUCT_W-1:0] sched_tx_req_data,
  output logic                          sched_tx_req_rdy,
  output logic                          tx_pkt_req_val,
  output logic [FLOWID_W-1:0]           tx_pkt_req_flowid,
  output logic [1:0]                    tx_pkt_req_type,
  input  logic                          tx_pkt_req_rdy,
  output logic                          tx_sched_update_val,
  output logic [SCHED_CMD_STRUCT_W-1:0] tx_sched_update_cmd,
  input  logic                          tx_sched_update_rdy,
  output logic [15:0]                   pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  state_e              state_q;
  logic [FLOWID_W-1:0] flowid_q;
  logic [2:0]          pend_q;   // bit0 RT, bit1 DATA, bit2 ACK
  logic [2:0]          svc_q;
  logic [15:0]         pkt_cnt_q;
  logic                req_rdy_q;
  logic                pkt_val_q;
  logic                upd_val_q;

  sched_data_struct    req;
  logic [2:0]          req_pend;
  tx_pkt_type_e        sel_type;
  logic [2:0]          sel_oh;
  logic [2:0]          clr_mask;
  logic [2:0]          pend_d;
  logic [2:0]          svc_d;
  sched_cmd_struct     cmd;

  assign req      = sched_data_struct'(sched_tx_req_data);
  assign req_pend = {req.ack_pend_flag, req.data_pend_flag, req.rt_flag};

  tx_pkt_prio_sel u_prio_sel (
    .pend_i   (pend_q),
    .type_o   (sel_type),
    .onehot_o (sel_oh)
  );

`ifdef TX_DISPATCH_ACK_PIGGYBACK_EN
  // A DATA packet also carries a pending ACK; only claim ACK if it was pending.
  assign clr_mask = {sel_oh[2] | (sel_oh[1] & pend_q[2]), sel_oh[1:0]};
`else
  assign clr_mask = sel_oh;
`endif

  assign pend_d = pend_q & ~clr_mask;
  assign svc_d  = svc_q | clr_mask;

  // Clear command covers serviced flags only; others stay NOP.
  always_comb begin
    cmd                     = '0;
    cmd.flowid              = flowid_q;
    cmd.rt_set_clear        = clr_if_serviced(svc_q[0]);
    cmd.data_pend_set_clear = clr_if_serviced(svc_q[1]);
    cmd.ack_pend_set_clear  = clr_if_serviced(svc_q[2]);
  end

  // Dispatch FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      flowid_q  <= '0;
      pend_q    <= 3'b000;
      svc_q     <= 3'b000;
      pkt_cnt_q <= 16'h0000;
      req_rdy_q <= 1'b1;
      pkt_val_q <= 1'b0;
      upd_val_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sched_tx_req_val) begin
            flowid_q <= req.flowid;
            pend_q   <= req_pend;
            svc_q    <= 3'b000;
            // A flow with nothing pending is consumed without any output.
            if (|req_pend) begin
              state_q   <= ST_ISSUE;
              req_rdy_q <= 1'b0;
              pkt_val_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (tx_pkt_req_rdy) begin
            pend_q    <= pend_d;
            svc_q     <= svc_d;
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (pend_d == 3'b000) begin
              state_q   <= ST_UPDATE;
              pkt_val_q <= 1'b0;
              upd_val_q <= 1'b1;
            end
          end
        end
        ST_UPDATE: begin
          if (tx_sched_update_rdy) begin
            state_q   <= ST_IDLE;
            upd_val_q <= 1'b0;
            req_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          req_rdy_q <= 1'b1;
          pkt_val_q <= 1'b0;
          upd_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign sched_tx_req_rdy    = req_rdy_q;
  assign tx_pkt_req_val      = pkt_val_q;
  assign tx_pkt_req_flowid   = flowid_q;
  assign tx_pkt_req_type     = sel_type;
  assign tx_sched_update_val = upd_val_q;
  assign tx_sched_update_cmd = cmd;
  assign pkt_cnt             = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_sched_dispatch.sv
// ---------------------------------------------------------------------------
// tb_tx_sched_dispatch
// Directed self-checking bench for tx_sched_dispatch. Expectations follow
// TX_DISPATCH_ACK_PIGGYBACK_EN when it is defined for the build.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tx_sched_dispatch;
  import tcp_misc_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic                          sched_tx_req_val = 1'b0;
  logic [SCHED_DATA_STRUCT_W-1:0] sched_tx_req_data = '0;
  logic                          sched_tx_req_rdy;
  logic                          tx_pkt_req_val;
  logic [FLOWID_W-1:0]           tx_pkt_req_flowid;
  logic [1:0]                    tx_pkt_req_type;
  logic                          tx_pkt_req_rdy = 1'b1;
  logic                          tx_sched_update_val;
  logic [SCHED_CMD_STRUCT_W-1:0] tx_sched_update_cmd;
  logic                          tx_sched_update_rdy = 1'b1;
  logic [15:0]                   pkt_cnt;

  int checks = 0;
  int errors = 0;

  logic [FLOWID_W+1:0]           pkt_q[$];
  logic [SCHED_CMD_STRUCT_W-1:0] cmd_q[$];

  always #5 clk = ~clk;

  tx_sched_dispatch dut (
    .clk                 (clk),
    .rst                 (rst),
    .sched_tx_req_val    (sched_tx_req_val),
    .sched_tx_req_data   (sched_tx_req_data),
    .sched_tx_req_rdy    (sched_tx_req_rdy),
    .tx_pkt_req_val      (tx_pkt_req_val),
    .tx_pkt_req_flowid   (tx_pkt_req_flowid),
    .tx_pkt_req_type     (tx_pkt_req_type),
    .tx_pkt_req_rdy      (tx_pkt_req_rdy),
    .tx_sched_update_val (tx_sched_update_val),
    .tx_sched_update_cmd (tx_sched_update_cmd),
    .tx_sched_update_rdy (tx_sched_update_rdy),
    .pkt_cnt             (pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FLOWID_W+1:0] pk(input logic [FLOWID_W-1:0] f, input tx_pkt_type_e t);
    return {f, t};
  endfunction

  function automatic logic [SCHED_CMD_STRUCT_W-1:0] mkcmd(input logic [FLOWID_W-1:0] f,
      input flag_cmd_e rt, input flag_cmd_e ack, input flag_cmd_e data);
    sched_cmd_struct c;
    c.flowid              = f;
    c.rt_set_clear        = rt;
    c.ack_pend_set_clear  = ack;
    c.data_pend_set_clear = data;
    return c;
  endfunction

  // Record every handshake, sampled mid-low-phase after inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst && tx_pkt_req_val && tx_pkt_req_rdy)
      pkt_q.push_back({tx_pkt_req_flowid, tx_pkt_req_type});
    if (!rst && tx_sched_update_val && tx_sched_update_rdy)
      cmd_q.push_back(tx_sched_update_cmd);
  end

  task automatic clear_q();
    pkt_q.delete();
    cmd_q.delete();
  endtask

  // Offer one flow; optionally check the first-packet latency.
  task automatic send(input logic [FLOWID_W-1:0] f, input logic rt, input logic ack,
                      input logic data, input bit lat_chk);
    int guard = 0;
    @(negedge clk);
    sched_tx_req_data = {f, rt, ack, data};
    sched_tx_req_val  = 1'b1;
    while (!sched_tx_req_rdy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!sched_tx_req_rdy) chk("accept_timeout", 32'(sched_tx_req_rdy), 32'd1);
    @(negedge clk);
    sched_tx_req_val = 1'b0;
    if (lat_chk) begin
      chk("lat_pkt_val", 32'(tx_pkt_req_val), 32'd1);
      chk("lat_rdy_low", 32'(sched_tx_req_rdy), 32'd0);
    end
  endtask

  task automatic wait_cmd(input int n);
    int guard = 0;
    while (cmd_q.size() < n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (cmd_q.size() < n) chk("cmd_timeout", 32'(cmd_q.size()), 32'(n));
    @(negedge clk);
  endtask

  initial begin
    int guard;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_rdy", 32'(sched_tx_req_rdy), 32'd1);
    chk("rst_pkt_val", 32'(tx_pkt_req_val), 32'd0);
    chk("rst_upd_val", 32'(tx_sched_update_val), 32'd0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Flow 5, RT only
    clear_q();
    send(10'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cmd(1);
    chk("f5_npkt", 32'(pkt_q.size()), 32'd1);
    if (pkt_q.size() >= 1) chk("f5_pkt0", 32'(pkt_q[0]), 32'(pk(10'd5, PKT_RT)));
    if (cmd_q.size() >= 1) chk("f5_cmd", 32'(cmd_q[0]), 32'(mkcmd(10'd5, FLAG_CLEAR, FLAG_NOP, FLAG_NOP)));
    chk("f5_cnt", 32'(pkt_cnt), 32'd1);
    chk("f5_idle_rdy", 32'(sched_tx_req_rdy), 32'd1);

    // Flow 3, all flags
    clear_q();
    send(10'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_cmd(1);
`ifdef TX_DISPATCH_ACK_PIGGYBACK_EN
    chk("f3_npkt", 32'(pkt_q.size()), 32'd2);
    if (pkt_q.size() >= 2) begin
      chk("f3_pkt0", 32'(pkt_q[0]), 32'(pk(10'd3, PKT_RT)));
      chk("f3_pkt1", 32'(pkt_q[1]), 32'(pk(10'd3, PKT_DATA)));
    end
    chk("f3_cnt", 32'(pkt_cnt), 32'd3);
`else
    chk("f3_npkt", 32'(pkt_q.size()), 32'd3);
    if (pkt_q.size() >= 3) begin
      chk("f3_pkt0", 32'(pkt_q[0]), 32'(pk(10'd3, PKT_RT)));
      chk("f3_pkt1", 32'(pkt_q[1]), 32'(pk(10'd3, PKT_DATA)));
      chk("f3_pkt2", 32'(pkt_q[2]), 32'(pk(10'd3, PKT_ACK)));
    end
    chk("f3_cnt", 32'(pkt_cnt), 32'd4);
`endif
    if (cmd_q.size() >= 1) chk("f3_cmd", 32'(cmd_q[0]), 32'(mkcmd(10'd3, FLAG_CLEAR, FLAG_CLEAR, FLAG_CLEAR)));
    chk("f3_ncmd", 32'(cmd_q.size()), 32'd1);

    // Flow 9, DATA + ACK; RT not serviced must stay NOP
    clear_q();
    send(10'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_cmd(1);
`ifdef TX_DISPATCH_ACK_PIGGYBACK_EN
    chk("f9_npkt", 32'(pkt_q.size()), 32'd1);
`else
    chk("f9_npkt", 32'(pkt_q.size()), 32'd2);
    if (pkt_q.size() >= 2) chk("f9_pkt1", 32'(pkt_q[1]), 32'(pk(10'd9, PKT_ACK)));
`endif
    if (pkt_q.size() >= 1) chk("f9_pkt0", 32'(pkt_q[0]), 32'(pk(10'd9, PKT_DATA)));
    if (cmd_q.size() >= 1) chk("f9_cmd", 32'(cmd_q[0]), 32'(mkcmd(10'd9, FLAG_NOP, FLAG_CLEAR, FLAG_CLEAR)));

    // Flow 7 with no flags: nothing issued
    clear_q();
    send(10'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("f7_npkt", 32'(pkt_q.size()), 32'd0);
    chk("f7_ncmd", 32'(cmd_q.size()), 32'd0);
    chk("f7_rdy", 32'(sched_tx_req_rdy), 32'd1);
    chk("f7_pkt_val", 32'(tx_pkt_req_val), 32'd0);

    // Flow 2 ACK only with packet back-pressure for 4 cycles
    clear_q();
    tx_pkt_req_rdy = 1'b0;
    send(10'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_val", 32'(tx_pkt_req_val), 32'd1);
      chk("stall_pkt", 32'({tx_pkt_req_flowid, tx_pkt_req_type}), 32'(pk(10'd2, PKT_ACK)));
      chk("stall_req_rdy", 32'(sched_tx_req_rdy), 32'd0);
    end
    chk("stall_npkt", 32'(pkt_q.size()), 32'd0);
    tx_pkt_req_rdy = 1'b1;
    wait_cmd(1);
    chk("f2_npkt", 32'(pkt_q.size()), 32'd1);
    if (cmd_q.size() >= 1) chk("f2_cmd", 32'(cmd_q[0]), 32'(mkcmd(10'd2, FLAG_NOP, FLAG_CLEAR, FLAG_NOP)));

    // Counter wrap: bring pkt_cnt to 0xFFFF, then one more packet
    @(negedge clk);
    force dut.pkt_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_cnt_q;
    @(negedge clk);
    guard = 0;
    while (pkt_cnt != 16'hFFFF && guard < 70000) begin
      clear_q();
      if ((16'hFFFF - pkt_cnt) >= 16'd3) send(10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      else send(10'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      wait_cmd(1);
      guard++;
    end
    chk("cnt_preload", 32'(pkt_cnt), 32'hFFFF);
    clear_q();
    send(10'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_cmd(1);
    chk("cnt_wrap", 32'(pkt_cnt), 32'h0000);

    // Reset during ISSUE abandons the flow
    clear_q();
    tx_pkt_req_rdy = 1'b0;
    send(10'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rsti_pkt_val", 32'(tx_pkt_req_val), 32'd0);
    rst = 1'b0;
    tx_pkt_req_rdy = 1'b1;
    repeat (4) @(negedge clk);
    chk("rsti_npkt", 32'(pkt_q.size()), 32'd0);
    chk("rsti_ncmd", 32'(cmd_q.size()), 32'd0);

    // Reset during UPDATE abandons the command
    clear_q();
    tx_sched_update_rdy = 1'b0;
    send(10'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    guard = 0;
    while (!tx_sched_update_val && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("upd_val_wait", 32'(tx_sched_update_val), 32'd1);
    chk("upd_cmd_hold", 32'(tx_sched_update_cmd), 32'(mkcmd(10'd4, FLAG_CLEAR, FLAG_NOP, FLAG_NOP)));
    chk("upd_cnt", 32'(pkt_cnt), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstu_upd_val", 32'(tx_sched_update_val), 32'd0);
    chk("rstu_cnt", 32'(pkt_cnt), 32'd0);
    rst = 1'b0;
    tx_sched_update_rdy = 1'b1;
    @(negedge clk);
    chk("rstu_req_rdy", 32'(sched_tx_req_rdy), 32'd1);
    repeat (3) @(negedge clk);
    chk("rstu_ncmd", 32'(cmd_q.size()), 32'd0);
    chk("rstu_npkt", 32'(pkt_q.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
